// File: rtl/br_resolve_if.sv
// Execute-stage branch resolution bundle: branch operands in, resolution,
// flush, redirect handshake and statistics out.
interface br_resolve_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             br_valid_i;
    logic             br_ready_o;
    logic [2:0]       br_funct3_i;
    logic [XLEN-1:0]  br_pc_i;
    logic [XLEN-1:0]  br_imm_i;
    logic             br_pred_taken_i;
    logic [2:0]       scomp_i;
    logic [2:0]       ucomp_i;
    logic             resolve_valid_o;
    logic             resolve_taken_o;
    logic             mispredict_o;
    logic             flush_o;
    logic             redirect_valid_o;
    logic             redirect_ready_i;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             err_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    // Pipeline / fetch side: supplies the branch and accepts the redirect.
    modport master (
        output br_valid_i, br_funct3_i, br_pc_i, br_imm_i, br_pred_taken_i,
               scomp_i, ucomp_i, redirect_ready_i,
        input  br_ready_o, resolve_valid_o, resolve_taken_o, mispredict_o,
               flush_o, redirect_valid_o, redirect_pc_o, err_o,
               branch_cnt_o, mispred_cnt_o
    );

    // Branch resolve unit side.
    modport slave (
        input  br_valid_i, br_funct3_i, br_pc_i, br_imm_i, br_pred_taken_i,
               scomp_i, ucomp_i, redirect_ready_i,
        output br_ready_o, resolve_valid_o, resolve_taken_o, mispredict_o,
               flush_o, redirect_valid_o, redirect_pc_o, err_o,
               branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves B-type branches from comparator results, checks the fetch prediction
// and issues a flush plus a held redirect request on a mispredict.
module branch_resolve_unit #(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input logic        clk,
    input logic        rst,
    br_resolve_if.slave bus
);
    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      sel_cmp;
    logic            cmp_onehot;
    logic            funct3_bad;
    logic            illegal;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        taken      = 1'b0;
        sel_cmp    = (bus.br_funct3_i[2:1] == 2'b11) ? bus.ucomp_i : bus.scomp_i;
        cmp_onehot = (sel_cmp == 3'b001) || (sel_cmp == 3'b010) || (sel_cmp == 3'b100);
        funct3_bad = (bus.br_funct3_i[2:1] == 2'b01);
        illegal    = funct3_bad || !cmp_onehot;
        case (bus.br_funct3_i)
            3'b000:  taken =  sel_cmp[1];
            3'b001:  taken = !sel_cmp[1];
            3'b100:  taken =  sel_cmp[0];
            3'b101:  taken = !sel_cmp[0];
            3'b110:  taken =  sel_cmp[0];
            3'b111:  taken = !sel_cmp[0];
            default: taken = 1'b0;
        endcase
        mispredict = taken ^ bus.br_pred_taken_i;
        target     = taken ? bus.br_pc_i + bus.br_imm_i : bus.br_pc_i + XLEN'(4);
    end

    // NOTE: state and outputs use non-blocking assignments so every output is a clean flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            bus.br_ready_o       <= 1'b1;
            bus.resolve_valid_o  <= 1'b0;
            bus.resolve_taken_o  <= 1'b0;
            bus.mispredict_o     <= 1'b0;
            bus.flush_o          <= 1'b0;
            bus.err_o            <= 1'b0;
            bus.redirect_valid_o <= 1'b0;
            bus.redirect_pc_o    <= '0;
            bus.branch_cnt_o     <= '0;
            bus.mispred_cnt_o    <= '0;
        end else begin
            bus.resolve_valid_o <= 1'b0;
            bus.resolve_taken_o <= 1'b0;
            bus.mispredict_o    <= 1'b0;
            bus.flush_o         <= 1'b0;
            bus.err_o           <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.br_valid_i) begin
                        bus.resolve_valid_o <= 1'b1;
                        if (illegal) begin
                            bus.err_o <= 1'b1;
                        end else begin
                            bus.resolve_taken_o <= taken;
                            bus.branch_cnt_o    <= sat_inc(bus.branch_cnt_o);
                            if (mispredict) begin
                                bus.mispredict_o     <= 1'b1;
                                bus.flush_o          <= 1'b1;
                                bus.redirect_valid_o <= 1'b1;
                                bus.redirect_pc_o    <= target;
                                bus.mispred_cnt_o    <= sat_inc(bus.mispred_cnt_o);
                                bus.br_ready_o       <= 1'b0;
                                state                <= REDIRECT;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    // Target stays on redirect_pc_o until fetch takes it.
                    if (bus.redirect_ready_i) begin
                        bus.redirect_valid_o <= 1'b0;
                        bus.br_ready_o       <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.br_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected
// resolutions plus per-scenario checks of handshake, wrap, errors and counters.
module tb_branch_resolve_unit;
    typedef struct packed {
        logic        err;
        logic        taken;
        logic        mis;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   tests;
    int   fails;
    int   resolved_seen;
    int   exp_branch;
    int   exp_mispred;

    br_resolve_if #(.XLEN(32), .CNT_W(16)) bif ();
    br_resolve_if #(.XLEN(32), .CNT_W(2))  sif ();

    branch_resolve_unit #(.CNT_W(16), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    branch_resolve_unit #(.CNT_W(2), .XLEN(32)) sat_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: pops one expectation per resolve pulse.
    task automatic mon_loop();
        exp_t       e;
        logic [4:0] got;
        logic [4:0] want;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bif.resolve_valid_o) begin
                    resolved_seen++;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected_resolve: got resolve_valid=1 required 0");
                    end else begin
                        e    = sb.pop_front();
                        got  = {bif.err_o, bif.resolve_taken_o, bif.mispredict_o,
                                bif.flush_o, bif.redirect_valid_o};
                        want = {e.err, e.taken, e.mis, e.mis, e.mis};
                        if (got !== want) begin
                            fails++;
                            $display("FAIL sb_resolve {err,taken,mis,flush,rv}: got %b required %b", got, want);
                        end
                        if (e.mis) begin
                            tests++;
                            if (bif.redirect_pc_o !== e.pc) begin
                                fails++;
                                $display("FAIL sb_redirect_pc: got %h required %h", bif.redirect_pc_o, e.pc);
                            end
                        end
                    end
                end else begin
                    tests++;
                    if ({bif.mispredict_o, bif.flush_o, bif.err_o} !== 3'b000) begin
                        fails++;
                        $display("FAIL stray_pulse {mis,flush,err}: got %b required 000",
                                 {bif.mispredict_o, bif.flush_o, bif.err_o});
                    end
                end
            end
        end
    endtask

    // Drives one branch for a single accepting cycle and records what it must produce.
    task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic [2:0] sc, input logic [2:0] uc,
                         input logic e_err, input logic e_taken, input logic e_mis,
                         input logic [31:0] e_pc);
        exp_t e;
        bif.br_funct3_i     = f3;
        bif.br_pc_i         = pc;
        bif.br_imm_i        = imm;
        bif.br_pred_taken_i = pred;
        bif.scomp_i         = sc;
        bif.ucomp_i         = uc;
        bif.br_valid_i      = 1'b1;
        e.err   = e_err;
        e.taken = e_taken;
        e.mis   = e_mis;
        e.pc    = e_pc;
        sb.push_back(e);
        if (!e_err) exp_branch++;
        if (!e_err && e_mis) exp_mispred++;
        @(posedge clk);
        #1;
        bif.br_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bif.br_ready_o, bif.resolve_valid_o, bif.resolve_taken_o, bif.mispredict_o,
             bif.flush_o, bif.redirect_valid_o, bif.err_o} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_flags {rdy,rv,tk,mis,fl,rdv,err}: got %b required 1000000",
                     {bif.br_ready_o, bif.resolve_valid_o, bif.resolve_taken_o, bif.mispredict_o,
                      bif.flush_o, bif.redirect_valid_o, bif.err_o});
        end
        tests++;
        if (bif.redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_redirect_pc: got %h required 00000000", bif.redirect_pc_o);
        end
        tests++;
        if ({bif.branch_cnt_o, bif.mispred_cnt_o} !== 32'h0) begin
            fails++;
            $display("FAIL reset_counters: got %h/%h required 0/0", bif.branch_cnt_o, bif.mispred_cnt_o);
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        exp_branch  = 0;
        exp_mispred = 0;
    endtask

    task automatic test_beq_redirect();
        bif.redirect_ready_i = 1'b0;
        issue(3'b000, 32'h100, 32'h20, 1'b0, 3'b010, 3'b010, 1'b0, 1'b1, 1'b1, 32'h120);
        // A valid branch offered during REDIRECT must be ignored.
        bif.br_funct3_i = 3'b001;
        bif.br_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({bif.redirect_valid_o, bif.br_ready_o} !== 2'b10) begin
                fails++;
                $display("FAIL beq_hold[%0d] {rdv,rdy}: got %b required 10", i,
                         {bif.redirect_valid_o, bif.br_ready_o});
            end
            tests++;
            if (bif.redirect_pc_o !== 32'h120) begin
                fails++;
                $display("FAIL beq_hold_pc[%0d]: got %h required 00000120", i, bif.redirect_pc_o);
            end
        end
        bif.redirect_ready_i = 1'b1;
        bif.br_valid_i       = 1'b0;
        @(negedge clk);
        tests++;
        if ({bif.redirect_valid_o, bif.br_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL beq_handshake {rdv,rdy}: got %b required 01",
                     {bif.redirect_valid_o, bif.br_ready_o});
        end
        tests++;
        if (bif.branch_cnt_o !== 16'(exp_branch) || bif.mispred_cnt_o !== 16'(exp_mispred)) begin
            fails++;
            $display("FAIL beq_counters: got %0d/%0d required %0d/%0d",
                     bif.branch_cnt_o, bif.mispred_cnt_o, exp_branch, exp_mispred);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_blt_bltu();
        bif.redirect_ready_i = 1'b1;
        issue(3'b100, 32'h200, 32'h40, 1'b1, 3'b001, 3'b100, 1'b0, 1'b1, 1'b0, 32'h0);
        tests++;
        if ({bif.br_ready_o, bif.redirect_valid_o} !== 2'b10) begin
            fails++;
            $display("FAIL blt_no_redirect {rdy,rdv}: got %b required 10",
                     {bif.br_ready_o, bif.redirect_valid_o});
        end
        issue(3'b110, 32'h200, 32'h40, 1'b1, 3'b001, 3'b100, 1'b0, 1'b0, 1'b1, 32'h204);
        @(negedge clk);
        tests++;
        if (bif.redirect_valid_o !== 1'b1 || bif.redirect_pc_o !== 32'h204) begin
            fails++;
            $display("FAIL bltu_redirect: got rdv=%b pc=%h required rdv=1 pc=00000204",
                     bif.redirect_valid_o, bif.redirect_pc_o);
        end
        @(negedge clk);
        tests++;
        if ({bif.redirect_valid_o, bif.br_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL bltu_fast_handshake {rdv,rdy}: got %b required 01",
                     {bif.redirect_valid_o, bif.br_ready_o});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bge_wrap();
        issue(3'b101, 32'hFFFF_FFFC, 32'h10, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1, 1'b1, 32'h0000_000C);
        @(posedge clk);
        #1;
        issue(3'b101, 32'hFFFF_FFFC, 32'h10, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
        @(negedge clk);
        tests++;
        if (bif.redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL bge_wrap_pc: got %h required 00000000", bif.redirect_pc_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        issue(3'b010, 32'h400, 32'h8, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(3'b001, 32'h404, 32'h8, 1'b1, 3'b011, 3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tests++;
        if (bif.branch_cnt_o !== 16'(exp_branch) || bif.mispred_cnt_o !== 16'(exp_mispred)) begin
            fails++;
            $display("FAIL err_counters: got %0d/%0d required %0d/%0d",
                     bif.branch_cnt_o, bif.mispred_cnt_o, exp_branch, exp_mispred);
        end
        tests++;
        if ({bif.redirect_valid_o, bif.br_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL err_no_redirect {rdv,rdy}: got %b required 01",
                     {bif.redirect_valid_o, bif.br_ready_o});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int   seen0;
        logic tk;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        exp_branch  = 0;
        exp_mispred = 0;
        seen0       = resolved_seen;
        for (int i = 0; i < 5; i++) begin
            tk = (i % 2 == 0);
            issue(3'b000, 32'h1000 + 32'(4 * i), 32'h8, tk, tk ? 3'b010 : 3'b100,
                  3'b010, 1'b0, tk, 1'b0, 32'h0);
            tests++;
            if (bif.br_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", i, bif.br_ready_o);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (resolved_seen - seen0 != 5) begin
            fails++;
            $display("FAIL b2b_resolve_pulses: got %0d required 5", resolved_seen - seen0);
        end
        tests++;
        if (bif.branch_cnt_o !== 16'd5 || bif.mispred_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL b2b_counters: got %0d/%0d required 5/0", bif.branch_cnt_o, bif.mispred_cnt_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        int pulses = 0;
        int cyc    = 0;
        int want;
        sif.br_funct3_i      = 3'b000;
        sif.br_pc_i          = 32'h300;
        sif.br_imm_i         = 32'h10;
        sif.br_pred_taken_i  = 1'b0;
        sif.scomp_i          = 3'b010;
        sif.ucomp_i          = 3'b010;
        sif.redirect_ready_i = 1'b1;
        sif.br_valid_i       = 1'b1;
        while (pulses < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sif.resolve_valid_o) begin
                pulses++;
                want = (pulses > 3) ? 3 : pulses;
                tests++;
                if (sif.mispred_cnt_o !== 2'(want)) begin
                    fails++;
                    $display("FAIL sat_mispred_cnt[%0d]: got %0d required %0d", pulses, sif.mispred_cnt_o, want);
                end
                if (pulses == 5) sif.br_valid_i = 1'b0;
            end
        end
        sif.br_valid_i = 1'b0;
        tests++;
        if (pulses != 5) begin
            fails++;
            $display("FAIL sat_timeout: got %0d pulses required 5", pulses);
        end
        tests++;
        if (sif.branch_cnt_o !== 2'd3) begin
            fails++;
            $display("FAIL sat_branch_cnt: got %0d required 3", sif.branch_cnt_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_redirect();
        bif.redirect_ready_i = 1'b0;
        issue(3'b000, 32'h500, 32'h30, 1'b0, 3'b010, 3'b010, 1'b0, 1'b1, 1'b1, 32'h530);
        @(negedge clk);
        #1;
        tests++;
        if (bif.redirect_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_redirect: got %b required 1", bif.redirect_valid_o);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({bif.redirect_valid_o, bif.br_ready_o} !== 2'b01 || bif.redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_redirect: got rdv=%b rdy=%b pc=%h required rdv=0 rdy=1 pc=00000000",
                     bif.redirect_valid_o, bif.br_ready_o, bif.redirect_pc_o);
        end
        tests++;
        if ({bif.branch_cnt_o, bif.mispred_cnt_o} !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_counters: got %0d/%0d required 0/0", bif.branch_cnt_o, bif.mispred_cnt_o);
        end
        @(posedge clk);
        #1;
        rst                  = 1'b0;
        bif.redirect_ready_i = 1'b1;
        exp_branch           = 0;
        exp_mispred          = 0;
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        resolved_seen = 0;
        exp_branch    = 0;
        exp_mispred   = 0;
        rst           = 1'b1;
        bif.br_valid_i = 1'b0; bif.br_funct3_i = '0; bif.br_pc_i = '0; bif.br_imm_i = '0;
        bif.br_pred_taken_i = 1'b0; bif.scomp_i = '0; bif.ucomp_i = '0; bif.redirect_ready_i = 1'b0;
        sif.br_valid_i = 1'b0; sif.br_funct3_i = '0; sif.br_pc_i = '0; sif.br_imm_i = '0;
        sif.br_pred_taken_i = 1'b0; sif.scomp_i = '0; sif.ucomp_i = '0; sif.redirect_ready_i = 1'b0;
        fork
            mon_loop();
        join_none
        test_reset();
        test_beq_redirect();
        test_blt_bltu();
        test_bge_wrap();
        test_errors();
        test_back_to_back();
        test_saturate();
        test_reset_in_redirect();
        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Resolves conditional branches in the execute stage. It consumes the 3-bit signed and unsigned comparator results and the branch funct3, and decides whether the branch is taken. It checks that decision against the fetch-stage prediction. On a mispredict it raises a one-cycle flush and a redirect request to fetch, held under a valid/ready handshake; it also keeps saturating branch and mispredict counters.

Parameters:
CNT_W, 16, width of the branch and mispredict statistics counters (saturating)
XLEN, 32, PC/immediate width

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
br_valid_i  input  1  branch operands/results valid
br_ready_o  output  1  unit can accept a branch this cycle
br_funct3_i  input  3  B-type funct3
br_pc_i  input  XLEN  PC of branch
br_imm_i  input  XLEN  sign-extended B-immediate
br_pred_taken_i  input  1  fetch prediction
scomp_i  input  3  signed compare {gt,eq,lt}: 100 s1>s2, 010 equal, 001 s1<s2
ucomp_i  input  3  unsigned compare, same encoding
resolve_valid_o  output  1  one-cycle pulse: decision registered
resolve_taken_o  output  1  actual direction (valid with resolve_valid_o)
mispredict_o  output  1  one-cycle pulse with resolve_valid_o
flush_o  output  1  one-cycle pulse: kill younger instructions
redirect_valid_o  output  1  redirect request to fetch
redirect_ready_i  input  1  fetch accepts redirect
redirect_pc_o  output  XLEN  corrected PC
err_o  output  1  one-cycle pulse: illegal funct3 or non-one-hot compare result
branch_cnt_o  output  CNT_W  resolved branches
mispred_cnt_o  output  CNT_W  mispredicts

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE. br_ready_o=1. All pulses, resolve_taken_o and redirect_valid_o are 0. redirect_pc_o=0. Both counters are 0.
- FSM states: IDLE and REDIRECT. br_ready_o=1 only in IDLE.
- Accept: br_valid_i & br_ready_o in cycle N. All outputs are registered and appear at cycle N+1.
- Taken decode uses the selected result R:
  - 000 BEQ: R[1]
  - 001 BNE: !R[1]
  - 100 BLT: scomp[0]
  - 101 BGE: !scomp[0]
  - 110 BLTU: ucomp[0]
  - 111 BGEU: !ucomp[0]
  - R is scomp for 000/001/100/101 and ucomp for 110/111.
- Error: if funct3 is 010 or 011, or R is not one-hot, then at N+1 err_o=1, taken=0, mispredict=0, no flush or redirect, and no counter update. resolve_valid_o still pulses.
- Mispredict = taken XOR br_pred_taken_i.
- Redirect target:
  - actual taken: pc+imm
  - actual not taken: pc+4
  - Modulo 2^XLEN; wrap is silent.
- At N+1, the unit pulses resolve_valid_o and increments branch_cnt.
- On mispredict at N+1: mispredict_o=1, flush_o=1, redirect_valid_o=1, redirect_pc_o=target, mispred_cnt increments, and the FSM enters REDIRECT.
- Otherwise the FSM stays in IDLE. Back-to-back accepts every cycle are allowed.
- REDIRECT:
  - redirect_valid_o and redirect_pc_o are held stable until redirect_valid_o & redirect_ready_i.
  - In the handshake cycle M, redirect_valid_o drops and the FSM returns to IDLE at M+1 (br_ready_o=1 at M+1).
  - flush_o is not re-pulsed.
  - If redirect_ready_i is already high at N+1, the handshake completes at N+1.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- rst asserted in any state, including REDIRECT mid-handshake: return to the reset values on the next edge. The pending redirect is dropped and the counters are cleared.
- br_valid_i while br_ready_o=0 is ignored. Upstream holds its inputs.

Test Plan:
- BEQ, pc=0x100, imm=0x20, scomp=010, pred=0 -> at N+1: taken=1, mispredict=1, flush pulse, redirect_pc=0x120, state REDIRECT. Hold redirect_ready=0 for 3 cycles (valid stays high and br_ready=0), then ready=1 -> IDLE next cycle.
- BLT vs BLTU with s1=0xFFFFFFFF, s2=1 (scomp=001, ucomp=100), pred=1 -> BLT: taken=1, no mispredict, no redirect. BLTU: taken=0, mispredict, redirect_pc=pc+4.
- BGE pred=0, pc=0xFFFFFFFC, scomp=100 -> taken, mispredict, redirect_pc=0xFFFFFFFC+imm; with BGE not taken (scomp=001) and pred=1 -> redirect_pc=0x00000000 (wrap).
- funct3=010, then a valid BNE with scomp=011 -> err_o pulse each time, no flush, branch_cnt unchanged.
- 5 back-to-back correctly predicted branches -> br_ready stays 1, resolve_valid pulses 5 cycles, branch_cnt=5, mispred_cnt=0. With CNT_W=2, 5 mispredicts -> mispred_cnt saturates at 3.
- rst during REDIRECT with redirect_ready=0 -> next cycle redirect_valid=0, IDLE, counters 0.
